// File: rtl/keypad_decimal_entry_pkg.sv
// Shared key codes, keypad layout and entry FSM states
// for the keypad decimal entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  // Indexed by {row, col}; *, # and D map to KEY_NONE.
  localparam logic [3:0] KEYMAP [16] = '{
    KEY_1,    KEY_2, KEY_3,    KEY_ENTER,
    KEY_4,    KEY_5, KEY_6,    KEY_BKSP,
    KEY_7,    KEY_8, KEY_9,    KEY_CLR,
    KEY_NONE, KEY_0, KEY_NONE, KEY_NONE
  };

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/keypad_decimal_entry_scanner.sv
// keypad_scanner: column strobe, row sampling and
// scan-level debounce producing one key_evt per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = SCAN_DIV_W + 2;
  localparam int RW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEBOUNCE_SCANS);

  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic          sample;
  logic          scan_end;
  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [3:0]    lows;
  logic          one_hot;
  logic [1:0]    ri;
  logic [1:0]    hits;
  logic [1:0]    nx_hits;
  logic [3:0]    rc;
  logic [3:0]    nx_rc;
  logic [3:0]    last_rc;
  logic          pressed;
  logic [RW-1:0] run;
  logic [RW-1:0] run_inc;
  logic [RW-1:0] key_run;

  assign col_idx  = cnt[CW-1:SCAN_DIV_W];
  assign col      = ~(4'b0001 << col_idx);
  assign sample   = &cnt[SCAN_DIV_W-1:0];
  assign scan_end = &cnt;
  assign lows     = ~row_s;
  assign one_hot  = (lows != 4'd0) &&
                    ((lows & (lows - 4'd1)) == 4'd0);
  assign run_inc  = run + 1'b1;
  assign key_run  = (run != '0 && nx_rc == last_rc)
                  ? run_inc : RW'(1);

  // Two-flop synchronizer on the asynchronous row pins;
  // the dwell is long enough to absorb its delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Fold this sample into the scan: 0 hits, one key, or multi.
  always_comb begin
    ri      = '0;
    nx_hits = hits;
    nx_rc   = rc;
    for (int i = 0; i < 4; i++)
      if (lows[i]) ri = 2'(i);
    if (lows != 4'd0) begin
      if (hits == 2'd0 && one_hot) begin
        nx_hits = 2'd1;
        nx_rc   = {ri, col_idx};
      end else begin
        nx_hits = 2'd2;
      end
    end
  end

  // Scan counter, per-scan accumulation and press/release debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hits     <= '0;
      rc       <= '0;
      last_rc  <= '0;
      pressed  <= 1'b0;
      run      <= '0;
      key_evt  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      cnt     <= cnt + 1'b1;
      key_evt <= 1'b0;
      if (sample) begin
        hits <= nx_hits;
        rc   <= nx_rc;
      end
      if (scan_end) begin
        hits <= '0;
        unique case (1'b1)
          !pressed && nx_hits == 2'd1: begin
            last_rc <= nx_rc;
            if (key_run >= RUN_MAX) begin
              pressed  <= 1'b1;
              run      <= '0;
              key_evt  <= 1'b1;
              key_code <= KEYMAP[nx_rc];
            end else begin
              run <= key_run;
            end
          end
          pressed && nx_hits == 2'd0: begin
            if (run_inc >= RUN_MAX) begin
              pressed <= 1'b0;
              run     <= '0;
            end else begin
              run <= run_inc;
            end
          end
          default: run <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_decimal_entry.sv
// Keypad decimal entry: BCD digit buffer, ENTRY/HOLD FSM, valid/ready out.
// Define KEYPAD_ECHO_EN to add entry_bcd/entry_len live echo outputs.
module keypad_decimal_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 4,
  parameter int NUM_W          = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [NUM_W-1:0] num_out,
  output logic             num_valid,
  input  logic             num_ready
`ifdef KEYPAD_ECHO_EN
  ,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [2:0]              entry_len
`endif
);

  localparam logic [2:0] LEN_MAX = 3'(MAX_DIGITS);

  logic             key_evt;
  logic [3:0]       key_code;
  logic [3:0]       digits [MAX_DIGITS];
  logic [2:0]       len;
  logic [NUM_W-1:0] bin;
  logic             is_digit;
  state_t           state;

  assign is_digit = key_code <= KEY_9;

  keypad_scanner #(
    .SCAN_DIV_W    (SCAN_DIV_W),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .col     (col),
    .key_evt (key_evt),
    .key_code(key_code)
  );

  // BCD digits to binary, most significant digit first.
  always_comb begin
    bin = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--)
      bin = bin * NUM_W'(10) + NUM_W'(digits[i]);
  end

`ifdef KEYPAD_ECHO_EN
  // Live echo of the digit buffer for the display path.
  always_comb begin
    entry_bcd = '0;
    for (int i = 0; i < MAX_DIGITS; i++)
      entry_bcd[4*i +: 4] = digits[i];
  end
  assign entry_len = len;
`endif

  // Entry FSM: edit the buffer, commit on ENTER, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ENTRY;
      digits    <= '{default: '0};
      len       <= '0;
      num_out   <= '0;
      num_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_ENTRY: begin
          if (key_evt) begin
            unique case (1'b1)
              is_digit: begin
                if (len < LEN_MAX) begin
                  for (int i = MAX_DIGITS - 1; i > 0; i--)
                    digits[i] <= digits[i-1];
                  digits[0] <= key_code;
                  len       <= len + 1'b1;
                end
              end
              key_code == KEY_BKSP: begin
                if (len != '0) begin
                  for (int i = 0; i < MAX_DIGITS - 1; i++)
                    digits[i] <= digits[i+1];
                  digits[MAX_DIGITS-1] <= '0;
                  len <= len - 1'b1;
                end
              end
              key_code == KEY_CLR: begin
                digits <= '{default: '0};
                len    <= '0;
              end
              key_code == KEY_ENTER: begin
                if (len != '0) begin
                  num_out   <= bin;
                  num_valid <= 1'b1;
                  digits    <= '{default: '0};
                  len       <= '0;
                  state     <= ST_HOLD;
                end
              end
              default: ;
            endcase
          end
        end
        ST_HOLD: begin
          if (num_valid && num_ready) begin
            num_valid <= 1'b0;
            state     <= ST_ENTRY;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Bench for keypad_decimal_entry: keypad matrix model driven by a key
// sequence, checked against an integer-arithmetic entry model.
module tb_keypad_decimal_entry;

  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [13:0] num_out;
  logic        num_valid;
  logic        num_ready;
`ifdef KEYPAD_ECHO_EN
  logic [15:0] entry_bcd;
  logic [2:0]  entry_len;
`endif

  logic [15:0] held = '0;
  string       layout = "123A456B789C*0#D";
  int          errors = 0;
  int          checks = 0;
  int          xfer_q[$];
  int          exp_q[$];
  int          m_val;
  int          m_len;
  int          m_out;
  bit          m_hold;

  keypad_decimal_entry #(
    .SCAN_DIV_W    (2),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .num_out  (num_out),
    .num_valid(num_valid),
    .num_ready(num_ready)
`ifdef KEYPAD_ECHO_EN
    ,
    .entry_bcd(entry_bcd),
    .entry_len(entry_len)
`endif
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its row low while its column is low.
  always_comb begin
    row = 4'hF;
    for (int i = 0; i < 16; i++)
      if (held[i] && !col[i % 4]) row[i / 4] = 1'b0;
  end

  // Record every handshake that will complete on the next edge.
  always @(negedge clk)
    if (!rst && num_valid === 1'b1 && num_ready)
      xfer_q.push_back(int'(num_out));

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pos(input byte ch);
    for (int i = 0; i < 16; i++)
      if (layout[i] == ch) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_len  = 0;
    m_out  = 0;
    m_hold = 1'b0;
  endtask

  task automatic model_key(input byte ch);
    if (m_hold) return;
    if (ch >= "0" && ch <= "9") begin
      if (m_len < 4) begin
        m_val = m_val * 10 + int'(ch - "0");
        m_len++;
      end
    end else if (ch == "B") begin
      if (m_len > 0) begin
        m_val = m_val / 10;
        m_len--;
      end
    end else if (ch == "C") begin
      m_val = 0;
      m_len = 0;
    end else if (ch == "A" && m_len > 0) begin
      m_out = m_val;
      m_val = 0;
      m_len = 0;
      if (num_ready) exp_q.push_back(m_out);
      else m_hold = 1'b1;
    end
  endtask

  task automatic sync_check(input string tag);
    @(negedge clk);
    check({tag, " xfers"}, xfer_q.size(), exp_q.size());
    if (xfer_q.size() != exp_q.size()) begin
      xfer_q.delete();
      exp_q.delete();
    end
    while (xfer_q.size() > 0)
      check({tag, " value"}, xfer_q.pop_front(), exp_q.pop_front());
    check({tag, " valid"}, num_valid, m_hold);
    check({tag, " num_out"}, num_out, m_out);
  endtask

  task automatic tap(input byte ch, input int hold, input int rel);
    int p;
    p = pos(ch);
    @(posedge clk);
    #1 held[p] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 held[p] = 1'b0;
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic key(input byte ch, input int hold, input int rel);
    tap(ch, hold, rel);
    model_key(ch);
    sync_check($sformatf("key %c", ch));
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++)
      key(s[i], 4 * SCAN, 4 * SCAN);
  endtask

  initial begin
    rst       = 1'b1;
    num_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset col", col, 4'b1110);
    check("reset num_out", num_out, 0);
    check("reset valid", num_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    keys("1234A");
    keys("99999A");
    keys("56B7A");
    keys("3CA");
    keys("A");

    @(posedge clk);
    #1 num_ready = 1'b0;
    keys("42A");
    keys("8");
    @(posedge clk);
    #1 num_ready = 1'b1;
    exp_q.push_back(m_out);
    m_hold = 1'b0;
    @(negedge clk);
    check("valid before xfer", num_valid, 1);
    @(negedge clk);
    check("valid after xfer", num_valid, 0);
    sync_check("after xfer");
    keys("A");
    keys("7A");

    @(posedge clk);
    #1 begin
      held[pos("1")] = 1'b1;
      held[pos("5")] = 1'b1;
    end
    repeat (10 * SCAN) @(posedge clk);
    #1 held = '0;
    repeat (4 * SCAN) @(posedge clk);
    #1;
    sync_check("multi");
    keys("A");

    tap("1", SCAN, 4 * SCAN);
    sync_check("short press");
    keys("A");

    key("1", 10 * SCAN, 4 * SCAN);
    keys("A");

    @(posedge clk);
    #1 num_ready = 1'b0;
    keys("3A");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst valid", num_valid, 0);
    check("rst num_out", num_out, 0);
    check("rst col", col, 4'b1110);
    #1 num_ready = 1'b1;
    keys("5A");

    for (int n = 0; n < 40; n++)
      key(layout[$urandom_range(15, 0)],
          int'($urandom_range(6, 3)) * SCAN,
          int'($urandom_range(5, 3)) * SCAN);
    keys("A");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
